// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing popcount accumulator.
package sc_pkg;

  localparam int SC_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } sc_state_e;

endpackage

// File: rtl/sc_popcount.sv
// Combinational popcount built as a recursive balanced adder tree.
module sc_popcount #(
  parameter  int IN_WIDTH = 32,
  localparam int CNT_W    = $clog2(IN_WIDTH + 1)
) (
  input  logic [IN_WIDTH-1:0] bits,
  output logic [CNT_W-1:0]    count
);

  if (IN_WIDTH == 1) begin : g_leaf
    assign count = bits;
  end else begin : g_split
    localparam int LO_W = IN_WIDTH / 2;
    localparam int HI_W = IN_WIDTH - LO_W;

    logic [$clog2(LO_W+1)-1:0] lo_cnt;
    logic [$clog2(HI_W+1)-1:0] hi_cnt;

    sc_popcount #(.IN_WIDTH(LO_W)) u_lo (
      .bits  (bits[LO_W-1:0]),
      .count (lo_cnt)
    );

    sc_popcount #(.IN_WIDTH(HI_W)) u_hi (
      .bits  (bits[IN_WIDTH-1:LO_W]),
      .count (hi_cnt)
    );

    assign count = CNT_W'(lo_cnt) + CNT_W'(hi_cnt);
  end

endmodule

// File: rtl/sc_popcount_acc.sv
// Accumulates popcounts of FRAMES product words into one result with a ready/valid output.
// Optional macro SC_ACC_PIPE_EN registers the popcount before the adder (adds a FLUSH cycle).
module sc_popcount_acc
  import sc_pkg::*;
#(
  parameter  int IN_WIDTH  = SC_WORD_WIDTH,
  parameter  int FRAMES    = 4,
  localparam int OUT_WIDTH = $clog2(IN_WIDTH * FRAMES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_count
);

  localparam int PC_W  = $clog2(IN_WIDTH + 1);
  localparam int CNT_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  sc_state_e              state_q, state_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_count_q, out_count_d;

  logic [PC_W-1:0]        pc;
  logic [OUT_WIDTH-1:0]   add_term;
  logic [OUT_WIDTH-1:0]   acc_sum;
  logic                   accept;
  logic                   last_word;

  sc_popcount #(.IN_WIDTH(IN_WIDTH)) u_popcount (
    .bits  (in_data),
    .count (pc)
  );

  assign accept    = in_valid && in_ready_q;
  assign last_word = (cnt_q == CNT_W'(FRAMES - 1));

`ifdef SC_ACC_PIPE_EN
  // Popcount stage register; the adder consumes it one cycle after the handshake.
  localparam sc_state_e LAST_STATE = FLUSH;

  logic [PC_W-1:0] pipe_q, pipe_d;
  logic            pipe_vld_q, pipe_vld_d;

  always_comb begin
    pipe_vld_d = accept && !clear;
    pipe_d     = pipe_q;
    if (clear)       pipe_d = '0;
    else if (accept) pipe_d = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q     <= '0;
      pipe_vld_q <= 1'b0;
    end else begin
      pipe_q     <= pipe_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  assign add_term = pipe_vld_q ? OUT_WIDTH'(pipe_q) : '0;
`else
  localparam sc_state_e LAST_STATE = DONE;

  assign add_term = accept ? OUT_WIDTH'(pc) : '0;
`endif

  assign acc_sum = acc_q + add_term;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      out_count_d = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          acc_d = acc_sum;
          if (accept) begin
            if (last_word) begin
              cnt_d      = '0;
              state_d    = LAST_STATE;
              in_ready_d = 1'b0;
              if (LAST_STATE == DONE) begin
                out_valid_d = 1'b1;
                out_count_d = acc_sum;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          acc_d       = acc_sum;
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_count_d = acc_sum;
        end
        DONE: begin
          if (out_ready) begin
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_count_d = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;

endmodule
